deser_lanes: RTL and testbench
==============================

Name: deser_lanes

Overview:
- Multi-lane, parametrised deserializer.
- Collects LANES serial bits per accepted beat and assembles DATA_WIDTH-bit words over BEATS = DATA_WIDTH/LANES beats. MSB-first and LSB-first ordering are both supported.
- Adds start-of-frame resynchronisation with error reporting, and a 2-entry output buffer with valid/ready backpressure.
- Sits between a serial PHY/lane front-end and word-oriented datapath logic.

Parameters:
- DATA_WIDTH, 8: output word width; must be a multiple of LANES and ≥ 2.
- LANES, 2: serial bits accepted per beat; 1 ≤ LANES ≤ DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dir  in  1  1 = MSB-first, 0 = LSB-first; sampled on beat 0 only
- sof  in  1  start of frame; qualifies an accepted beat as beat 0
- in_valid  in  1  ser holds a valid beat
- in_ready  out  1  block can accept a beat
- ser  in  LANES  serial beat, one bit per lane
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  DATA_WIDTH  assembled word (buffer head)
- frame_err  out  1  one-cycle pulse: partial word discarded by sof

Behaviour:
- Reset (rst_n low, asynchronous), all cleared:
  - beat counter = 0, shift register = 0, dir_lat = 0, buffer empty.
  - out_valid = 0, out_data = 0, frame_err = 0, in_ready = 0 while in reset.
  - Reset mid-word or with buffered words discards everything; the first accepted beat after release is beat 0.
- Accept condition: acc = in_valid & in_ready, with in_ready = (buffer count < 2). in_ready is registered from the count, so it carries no combinational path from out_ready.
- Beat counter, width max(1, clog2(BEATS)):
  - On acc, increments and wraps BEATS-1 → 0.
  - On acc with sof = 1, this beat is beat 0 and the counter becomes 1 (or stays 0 when BEATS = 1).
- Direction latch: dir_lat <= dir on every acc that is beat 0 (counter == 0, or sof = 1). A dir change mid-word has no effect until the next word.
- Shift register update on acc, using the effective direction eff = (beat 0 ? dir : dir_lat):
  - eff = 1: sh <= {sh[DATA_WIDTH-LANES-1:0], ser}. The first beat ends in the top bits; ser[LANES-1] is the more significant bit within a beat.
  - eff = 0: sh <= {ser, sh[DATA_WIDTH-1:LANES]}. The first beat ends in the bottom bits; ser[0] is the least significant bit within a beat.
  - With sof on a beat-0 accept, the shift uses a cleared register.
- Word completion: an acc on beat BEATS-1 pushes the next-state shift value into the buffer.
  - out_valid rises the next cycle when the buffer was empty; latency is 1 clk from the final beat to out_valid.
- sof mid-word: acc with sof = 1 while counter ≠ 0:
  - The partial word is discarded.
  - frame_err pulses high for exactly 1 cycle on the following cycle.
  - The beat is taken as beat 0 of a new word.
  - sof with counter == 0 produces no error. sof without acc is ignored.
- Output buffer, 2 entries, FIFO order:
  - Pop on out_valid & out_ready. out_data/out_valid show the head entry.
  - out_data holds its value while out_valid & !out_ready.
  - Push and pop in the same cycle with count = 1: count stays 1, the new word becomes head on the next cycle, and out_valid stays high.
  - Count 2: in_ready = 0, so a non-final beat cannot be accepted either.
  - Popping from count 2 makes in_ready = 1 the next cycle.
- in_valid low: counter, shift register and dir_lat hold; there is no timeout and no partial flush.
- LANES = DATA_WIDTH: every accepted beat is a complete word, and sof never produces frame_err.

Test Plan:
- DATA_WIDTH=8, LANES=2, dir=1, out_ready=1, beats 2'b10, 2'b11, 2'b00, 2'b01 (sof on first) → out_data=8'hB1, out_valid high 1 cycle, 1 clk after the last beat.
- Same beats with dir=0 → 8'h4E; toggling dir to 1 after beat 0 still gives 8'h4E.
- out_ready=0, stream 3 words A1, B2, C3:
  - after word 2, in_ready=0 and beats of C3 stall;
  - then raise out_ready → pops A1, B2, then C3 in order with no loss and no duplicates;
  - out_data holds A1 while stalled.
- After 2 beats of a word, sof beat, then 3 more beats (2'b10, 2'b11, 2'b00, 2'b01 total) → frame_err 1-cycle pulse, then out_data=8'hB1, no partial word output.
- With count=1 and out_ready=1, complete a word in the pop cycle → out_valid stays high, next word follows in order; then assert rst_n=0 mid-word → out_valid=0, buffer empty, next word assembles from beat 0.
- DATA_WIDTH=5, LANES=1, dir=1, bits 1, 0, 1, 1, 0 → out_data=5'b10110; DATA_WIDTH=LANES=4, ser=4'hA → out_data=4'hA every beat.

Source files
------------

// File: rtl/deser_lanes_if.sv
// Bus bundle for deser_lanes: the serial lane input side and the assembled
// word output side, grouped so the block and its environment see one port.
interface deser_lanes_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2
);
    logic                  dir;
    logic                  sof;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      ser;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  frame_err;

    // Environment view: drives the serial beats and the downstream ready
    modport master (
        output dir, sof, in_valid, ser, out_ready,
        input  in_ready, out_valid, out_data, frame_err
    );

    // Deserializer view
    modport slave (
        input  dir, sof, in_valid, ser, out_ready,
        output in_ready, out_valid, out_data, frame_err
    );
endinterface

// File: rtl/deser_lanes.sv
// Multi-lane deserializer: gathers LANES bits per accepted beat into a
// DATA_WIDTH-bit word over DATA_WIDTH/LANES beats, MSB- or LSB-first.
// sof forces a beat to be beat 0 (discarding any partial word and flagging
// frame_err), and completed words queue in a 2-entry FIFO with valid/ready.
module deser_lanes #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    deser_lanes_if.slave bus
);
    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Registered state
    logic [CW-1:0]              cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0]      sh_q,        sh_d;
    logic                       dir_lat_q,   dir_lat_d;
    logic [1:0][DATA_WIDTH-1:0] buf_q,       buf_d;
    logic [1:0]                 count_q,     count_d;
    logic                       in_ready_q,  in_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic                       frame_err_q, frame_err_d;

    // Combinational helpers
    logic                  acc_s;
    logic                  beat0_s;
    logic [CW-1:0]         idx_s;
    logic                  last_s;
    logic                  eff_s;
    logic [DATA_WIDTH-1:0] base_s;
    logic [DATA_WIDTH-1:0] ser_ext_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic                  push_s;
    logic                  pop_s;

    // Beat acceptance, beat index and the shifted word for this beat
    always_comb begin
        acc_s     = bus.in_valid & in_ready_q;
        // sof restarts the word regardless of where the counter is
        beat0_s   = (cnt_q == CNT_ZERO) | bus.sof;
        idx_s     = bus.sof ? CNT_ZERO : cnt_q;
        last_s    = (idx_s == LAST_BEAT);
        // direction is only taken from the pin on beat 0, latched afterwards
        eff_s     = beat0_s ? bus.dir : dir_lat_q;
        base_s    = bus.sof ? {DATA_WIDTH{1'b0}} : sh_q;
        ser_ext_s = DATA_WIDTH'(bus.ser);
        // shifts are written without slices so LANES == DATA_WIDTH stays legal
        if (eff_s) begin
            shifted_s = (base_s << LANES) | ser_ext_s;
        end else begin
            shifted_s = (base_s >> LANES) | (ser_ext_s << (DATA_WIDTH - LANES));
        end
        push_s    = acc_s & last_s;
        pop_s     = out_valid_q & bus.out_ready;
    end

    // Next state for beat counter, shift register and direction latch
    always_comb begin
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        dir_lat_d = dir_lat_q;
        if (acc_s) begin
            cnt_d = last_s ? CNT_ZERO : (idx_s + CNT_ONE);
            sh_d  = shifted_s;
            if (beat0_s) begin
                dir_lat_d = bus.dir;
            end else begin
                dir_lat_d = dir_lat_q;
            end
        end else begin
            cnt_d     = cnt_q;
            sh_d      = sh_q;
            dir_lat_d = dir_lat_q;
        end
    end

    // Two-entry output FIFO; entry 0 is always the head shown on out_data
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf_d[0] = shifted_s;
                end else begin
                    buf_d[1] = shifted_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf_d[0] = buf_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // count stays; the new word lands behind whatever remains
                if (count_q == 2'd1) begin
                    buf_d[0] = shifted_s;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = shifted_s;
                end
            end
            default: begin
                buf_d   = buf_q;
                count_d = count_q;
            end
        endcase
    end

    // Output flags derived from next-state count so they are flop outputs
    always_comb begin
        in_ready_d  = (count_d < 2'd2);
        out_valid_d = (count_d != 2'd0);
        frame_err_d = acc_s & bus.sof & (cnt_q != CNT_ZERO);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= CNT_ZERO;
            sh_q        <= {DATA_WIDTH{1'b0}};
            dir_lat_q   <= 1'b0;
            buf_q       <= {(2*DATA_WIDTH){1'b0}};
            count_q     <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            dir_lat_q   <= dir_lat_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = buf_q[0];
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_deser_lanes.sv
// Bench for deser_lanes: three configurations (8/2, 5/1, 4/4), a vector
// table, directed multi-cycle sequences and a randomized stream checked
// against a word-level model (queue of expected words, frame_err count).
module tb_deser_lanes;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    deser_lanes_if #(.DATA_WIDTH(8), .LANES(2)) ifa ();
    deser_lanes_if #(.DATA_WIDTH(5), .LANES(1)) ifb ();
    deser_lanes_if #(.DATA_WIDTH(4), .LANES(4)) ifc ();

    deser_lanes #(.DATA_WIDTH(8), .LANES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    deser_lanes #(.DATA_WIDTH(5), .LANES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    deser_lanes #(.DATA_WIDTH(4), .LANES(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ferr_exp = 0;
    bit rand_ready = 1'b0;
    logic [7:0] exp_q [$];

    typedef struct {
        bit         d0;
        bit         d1;
        logic [1:0] b0, b1, b2, b3;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Word-level model of DUT A: every pop must match the oldest expected word
    task automatic mon_sample();
        logic [7:0] e;
        if (rst_n) begin
            if (ifa.frame_err) ferr_cnt++;
            if (ifa.out_valid && ifa.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h required=no_word", ifa.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_order", ifa.out_data, e);
                end
            end
        end
    endtask

    // One clock: sample at the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        mon_sample();
        @(posedge clk);
        #1;
        if (rand_ready) ifa.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Beat k of word w as seen on the lanes, straight from the ordering rules
    function automatic logic [1:0] beat_of(input logic [7:0] w, input bit d, input int k);
        logic [7:0] t;
        if (d) t = w >> (6 - 2*k);
        else   t = w >> (2*k);
        return t[1:0];
    endfunction

    task automatic send_beat_a(input logic s, input logic d, input logic [1:0] b);
        bit done = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.sof      = s;
        ifa.dir      = d;
        ifa.ser      = b;
        for (int n = 0; n < 200 && !done; n++) begin
            done = ifa.in_ready;
            tick();
        end
        if (!done) chk("beat_timeout", 32'd0, 32'd1);
        ifa.in_valid = 1'b0;
        ifa.sof      = 1'b0;
    endtask

    task automatic send_part_a(input logic [7:0] w, input bit d, input bit s,
                               input int first, input int last, input bit rnd);
        for (int k = first; k <= last; k++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            send_beat_a((k == 0) ? s : 1'b0,
                        (rnd && k != 0) ? 1'($urandom_range(0, 1)) : d,
                        beat_of(w, d, k));
        end
    endtask

    task automatic send_word_a(input logic [7:0] w, input bit d, input bit s);
        exp_q.push_back(w);
        send_part_a(w, d, s, 0, 3, 1'b0);
    endtask

    vec_t       tbl [6];
    logic [1:0] bv [4];
    logic [3:0] cvals [4];
    logic [4:0] bseq;
    logic [4:0] bexp [2];
    logic [7:0] w;
    bit         d;
    bit         need_sof;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 2'b10, 2'b11, 2'b00, 2'b01, 8'hB1};
        tbl[1] = '{1'b0, 1'b0, 2'b10, 2'b11, 2'b00, 2'b01, 8'h4E};
        tbl[2] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b01, 8'h4E};
        tbl[3] = '{1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 2'b01, 8'hB1};
        tbl[4] = '{1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b10, 8'hC2};
        tbl[5] = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 8'h83};
        cvals[0] = 4'hA; cvals[1] = 4'hA; cvals[2] = 4'h5; cvals[3] = 4'h3;
        bseq    = 5'b10110;
        bexp[0] = 5'b01101;
        bexp[1] = 5'b10110;

        ifa.in_valid = 1'b0; ifa.sof = 1'b0; ifa.dir = 1'b0; ifa.ser = 2'b00; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.sof = 1'b0; ifb.dir = 1'b0; ifb.ser = 1'b0;  ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.sof = 1'b0; ifc.dir = 1'b0; ifc.ser = 4'h0;  ifc.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", ifa.out_valid, 1'b0);
        chk("rst_out_data",  ifa.out_data, 8'h00);
        chk("rst_frame_err", ifa.frame_err, 1'b0);
        chk("rst_in_ready",  ifa.in_ready, 1'b0);
        chk("rst_b_data",    ifb.out_data, 5'h00);
        chk("rst_c_ready",   ifc.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", ifa.in_ready, 1'b1);

        // Vector table: one word each, latency and single-cycle valid
        for (int i = 0; i < 6; i++) begin
            bv[0] = tbl[i].b0; bv[1] = tbl[i].b1; bv[2] = tbl[i].b2; bv[3] = tbl[i].b3;
            exp_q.push_back(tbl[i].exp);
            for (int k = 0; k < 4; k++) begin
                if (k == 3) chk("tbl_pre_valid", ifa.out_valid, 1'b0);
                send_beat_a(k == 0, (k == 0) ? tbl[i].d0 : tbl[i].d1, bv[k]);
            end
            chk("tbl_valid", ifa.out_valid, 1'b1);
            chk("tbl_data", ifa.out_data, tbl[i].exp);
            tick();
            chk("tbl_valid_drop", ifa.out_valid, 1'b0);
        end

        // Backpressure: two words fill the buffer, third word stalls
        ifa.out_ready = 1'b0;
        send_word_a(8'hA1, 1'b1, 1'b1);
        send_word_a(8'hB2, 1'b1, 1'b1);
        chk("full_in_ready", ifa.in_ready, 1'b0);
        chk("full_head", ifa.out_data, 8'hA1);
        exp_q.push_back(8'hC3);
        ifa.in_valid = 1'b1; ifa.sof = 1'b1; ifa.dir = 1'b1; ifa.ser = beat_of(8'hC3, 1'b1, 0);
        repeat (5) tick();
        chk("stall_in_ready", ifa.in_ready, 1'b0);
        chk("stall_hold", ifa.out_data, 8'hA1);
        chk("stall_valid", ifa.out_valid, 1'b1);
        ifa.out_ready = 1'b1;
        send_beat_a(1'b1, 1'b1, beat_of(8'hC3, 1'b1, 0));
        send_part_a(8'hC3, 1'b1, 1'b0, 1, 3, 1'b0);
        repeat (3) tick();
        chk("bp_drained", exp_q.size(), 0);

        // sof mid-word: one frame_err pulse, partial word dropped
        ferr_cnt = 0;
        send_beat_a(1'b1, 1'b1, 2'b01);
        send_beat_a(1'b0, 1'b1, 2'b01);
        chk("ferr_before", ifa.frame_err, 1'b0);
        exp_q.push_back(8'hB1);
        send_beat_a(1'b1, 1'b1, 2'b10);
        chk("ferr_pulse", ifa.frame_err, 1'b1);
        send_beat_a(1'b0, 1'b1, 2'b11);
        chk("ferr_one_cycle", ifa.frame_err, 1'b0);
        send_beat_a(1'b0, 1'b1, 2'b00);
        send_beat_a(1'b0, 1'b1, 2'b01);
        chk("ferr_word", ifa.out_data, 8'hB1);
        repeat (2) tick();
        chk("ferr_count", ferr_cnt, 1);
        chk("ferr_drained", exp_q.size(), 0);

        // Push and pop in the same cycle with one word buffered
        ifa.out_ready = 1'b0;
        send_word_a(8'h5A, 1'b1, 1'b1);
        exp_q.push_back(8'h3C);
        send_part_a(8'h3C, 1'b0, 1'b1, 0, 2, 1'b0);
        ifa.out_ready = 1'b1;
        send_beat_a(1'b0, 1'b0, beat_of(8'h3C, 1'b0, 3));
        chk("pp_valid", ifa.out_valid, 1'b1);
        chk("pp_head", ifa.out_data, 8'h3C);
        tick();
        chk("pp_valid_drop", ifa.out_valid, 1'b0);
        chk("pp_drained", exp_q.size(), 0);

        // Reset with a buffered word and a partial word in flight
        ifa.out_ready = 1'b0;
        send_word_a(8'hC7, 1'b1, 1'b1);
        send_part_a(8'h11, 1'b1, 1'b1, 0, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", ifa.out_valid, 1'b0);
        chk("mrst_in_ready", ifa.in_ready, 1'b0);
        chk("mrst_data", ifa.out_data, 8'h00);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        ferr_cnt = 0;
        send_word_a(8'h96, 1'b1, 1'b0);
        chk("mrst_word", ifa.out_data, 8'h96);
        repeat (2) tick();
        chk("mrst_drained", exp_q.size(), 0);
        chk("mrst_no_ferr", ferr_cnt, 0);

        // 5-bit word, one lane, both orders
        for (int j = 0; j < 2; j++) begin
            chk("b_in_ready", ifb.in_ready, 1'b1);
            for (int k = 0; k < 5; k++) begin
                ifb.in_valid = 1'b1;
                ifb.sof      = (k == 0);
                ifb.dir      = (k == 0) ? 1'(j) : 1'(~j);
                ifb.ser      = bseq[4-k];
                tick();
            end
            ifb.in_valid = 1'b0;
            chk("b_valid", ifb.out_valid, 1'b1);
            chk("b_data", ifb.out_data, bexp[j]);
            tick();
            chk("b_valid_drop", ifb.out_valid, 1'b0);
        end

        // LANES == DATA_WIDTH: every beat is a word, sof never errors
        for (int j = 0; j < 4; j++) begin
            ifc.in_valid = 1'b1;
            ifc.sof      = (j == 1);
            ifc.dir      = 1'(j);
            ifc.ser      = cvals[j];
            tick();
            chk("c_valid", ifc.out_valid, 1'b1);
            chk("c_data", ifc.out_data, cvals[j]);
            chk("c_no_ferr", ifc.frame_err, 1'b0);
        end
        ifc.in_valid = 1'b0;
        ifc.sof      = 1'b0;
        tick();
        chk("c_valid_drop", ifc.out_valid, 1'b0);

        // Randomized stream with gaps, backpressure and aborted frames
        ferr_cnt   = 0;
        ferr_exp   = 0;
        need_sof   = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                send_part_a(8'($urandom), 1'($urandom_range(0, 1)), 1'b1,
                            0, $urandom_range(0, 2), 1'b1);
                need_sof = 1'b1;
                ferr_exp++;
            end
            w = 8'($urandom);
            d = 1'($urandom_range(0, 1));
            exp_q.push_back(w);
            send_part_a(w, d, need_sof ? 1'b1 : 1'($urandom_range(0, 1)), 0, 3, 1'b1);
            need_sof = 1'b0;
        end
        rand_ready    = 1'b0;
        ifa.out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        tick();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_ferr_count", ferr_cnt, ferr_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
